video_ula_serialiser: RTL

Video ULA pixel serialiser: consumes the character-rate enables from the timing generator and the video RAM byte fetched on the CRTC's slot. It converts each byte into 1, 2, 4 or 8 logical pixels and maps them through a 16-entry palette to 3-bit RGB. It also applies display-enable blanking, flash, cursor inversion and the teletext bypass. It sits between shared RAM / the CRTC and the VGA output stage, and includes the CPU-writable control and palette registers.

---
 rtl/video_ula_serialiser.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/video_ula_serialiser.sv
`default_nettype none
// ============================================================================
// Module   : video_ula_serialiser
// Purpose  : Video ULA byte-to-pixel serialiser with 16-entry palette, flash,
//            blanking, teletext bypass and optional cursor (ULA_CURSOR_EN).
// Revision : 1.0
// ============================================================================
module video_ula_serialiser (
    input  logic       PIXELCLK,
    input  logic       nRESET,
    input  logic       CRTCF_en,
    input  logic       CRTCS_en,
    input  logic       PROC_en,
    input  logic       nCS,
    input  logic       RnW,
    input  logic       A0,
    input  logic [7:0] DATA,
    input  logic [7:0] VDATA,
    input  logic       DISEN,
    input  logic       CURSOR,
    input  logic [2:0] TTX_RGB,
    output logic [2:0] RGB
);

    logic [7:0] ctrl_q, ctrl_d;
    logic [3:0] pal_q [16];
    logic [3:0] pal_d [16];
    logic [7:0] shift_q, shift_d;
    logic [2:0] phase_q, phase_d;
    logic       dis_l_q, dis_l_d;
    logic [2:0] rgb_q, rgb_d;

    logic       wr_strobe;
    logic       ld;
    logic       shift_now;
    logic [3:0] lcol;
    logic [3:0] ecol;
    logic [2:0] pcol;
    logic [2:0] vis;
    logic       cur_on;

    assign wr_strobe = PROC_en & ~nCS & ~RnW;
    assign ld        = ctrl_q[4] ? CRTCF_en : CRTCS_en;

    // CPU-visible control and palette registers
    always_comb begin
        ctrl_d = ctrl_q;
        for (int i = 0; i < 16; i++) begin
            pal_d[i] = pal_q[i];
        end
        if (wr_strobe) begin
            if (A0) begin
                pal_d[DATA[7:4]] = DATA[3:0];
            end else begin
                ctrl_d = DATA;
            end
        end
    end

    // Shift when the phase reaches the last clock of the selected pixel period
    always_comb begin
        case (ctrl_q[3:2])
            2'b00:   shift_now = (phase_q == 3'd7);
            2'b01:   shift_now = (phase_q[1:0] == 2'b11);
            2'b10:   shift_now = phase_q[0];
            default: shift_now = 1'b1;
        endcase
    end

    always_comb begin
        shift_d = shift_q;
        phase_d = phase_q;
        dis_l_d = dis_l_q;
        if (ld) begin
            shift_d = VDATA;
            dis_l_d = DISEN;
            phase_d = 3'd0;
        end else begin
            phase_d = phase_q + 3'd1;
            if (shift_now) begin
                shift_d = {shift_q[6:0], 1'b1};
            end
        end
    end

`ifdef ULA_CURSOR_EN
    logic [2:0] cur_cnt_q, cur_cnt_d;
    logic [2:0] cur_len;

    always_comb begin
        case (ctrl_q[6:5])
            2'b00:   cur_len = 3'd1;
            2'b01:   cur_len = 3'd2;
            default: cur_len = 3'd4;
        endcase
        cur_cnt_d = cur_cnt_q;
        if (ld) begin
            if (CURSOR && ctrl_q[7]) begin
                cur_cnt_d = cur_len;
            end else if (cur_cnt_q != 3'd0) begin
                cur_cnt_d = cur_cnt_q - 3'd1;
            end
        end
    end

    always_ff @(posedge PIXELCLK or negedge nRESET) begin
        if (!nRESET) begin
            cur_cnt_q <= 3'd0;
        end else begin
            cur_cnt_q <= cur_cnt_d;
        end
    end

    assign cur_on = (cur_cnt_q != 3'd0);
`else
    logic unused_cursor;

    assign unused_cursor = ^{CURSOR, ctrl_q[7:5]};
    assign cur_on        = 1'b0;
`endif

    // Colour pipeline: palette, flash, teletext/blanking, then cursor inversion
    always_comb begin
        lcol = {shift_q[7], shift_q[5], shift_q[3], shift_q[1]};
        ecol = pal_q[lcol];
        pcol = ecol[2:0] ^ 3'b111;
        if (ecol[3] && ctrl_q[0]) begin
            pcol = pcol ^ 3'b111;
        end
        if (ctrl_q[1]) begin
            vis = TTX_RGB;
        end else if (!dis_l_q) begin
            vis = 3'b000;
        end else begin
            vis = pcol;
        end
        rgb_d = cur_on ? (vis ^ 3'b111) : vis;
    end

    always_ff @(posedge PIXELCLK or negedge nRESET) begin
        if (!nRESET) begin
            ctrl_q  <= 8'h00;
            shift_q <= 8'h00;
            phase_q <= 3'd0;
            dis_l_q <= 1'b0;
            rgb_q   <= 3'b000;
            for (int i = 0; i < 16; i++) begin
                pal_q[i] <= 4'h0;
            end
        end else begin
            ctrl_q  <= ctrl_d;
            shift_q <= shift_d;
            phase_q <= phase_d;
            dis_l_q <= dis_l_d;
            rgb_q   <= rgb_d;
            for (int i = 0; i < 16; i++) begin
                pal_q[i] <= pal_d[i];
            end
        end
    end

    assign RGB = rgb_q;

endmodule
`default_nettype wire
